// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: FSM encoding, blank
// patterns and the active-low hex decode table.
package seg_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   localparam logic [3:0] AN_OFF  = 4'b1111;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Active-low {g,f,e,d,c,b,a}; entry 15 first, entry 0 last
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b1000110,  // C
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0010000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_7seg
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   // Table lookup
   always_comb begin
      seg = SEG_TABLE[hex];
   end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed 4-digit 7-segment scanner with blanking dead-time and a
// scrolling message buffer that moves only on frame boundaries.
module seg_scan_controller
   import seg_pkg::*;
#(
   parameter int unsigned DIV_W   = 16,
   parameter int unsigned DIV_MAX = 49999,
   parameter int unsigned DEAD    = 16,
   parameter int unsigned MSG_LEN = 16,
   parameter int unsigned PTR_W   = $clog2(MSG_LEN)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 msg_load,
   input  logic [4*MSG_LEN-1:0] msg_data,
   input  logic                 advance,
   output logic [3:0]           an,
   output logic [6:0]           seg,
   output logic                 frame_done
);

   localparam int unsigned IDX_W = PTR_W + 1;
   localparam logic [DIV_W-1:0] CNT_BLANK_LAST = DIV_W'(DEAD - 1);
   localparam logic [DIV_W-1:0] CNT_DRIVE_LAST = DIV_W'(DIV_MAX);
   localparam logic [IDX_W-1:0] IDX_LEN        = IDX_W'(MSG_LEN);
   localparam logic [PTR_W-1:0] PTR_LAST       = PTR_W'(MSG_LEN - 1);

   state_t                  state;
   logic [1:0]              digit;
   logic [DIV_W-1:0]        cnt;
   logic [PTR_W-1:0]        ptr;
   logic                    pending;
   logic [MSG_LEN-1:0][3:0] msg_buf;

   logic [IDX_W-1:0]        idx_sum;
   logic [IDX_W-1:0]        idx;
   logic [PTR_W-1:0]        ptr_next;
   logic [3:0]              nibble;
   logic [6:0]              seg_dec;

   // Buffer index for the current digit; sum < 2*MSG_LEN so one subtract
   // reduces it, which keeps non-power-of-two lengths legal
   always_comb begin
      idx_sum  = IDX_W'(ptr) + IDX_W'(digit);
      idx      = (idx_sum >= IDX_LEN) ? (idx_sum - IDX_LEN) : idx_sum;
      nibble   = msg_buf[idx[PTR_W-1:0]];
      ptr_next = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
   end

   hex_to_7seg u_dec (
      .hex (nibble),
      .seg (seg_dec)
   );

   // Scan FSM with registered digit enables, segments and frame pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_BLANK;
         digit      <= 2'd0;
         cnt        <= '0;
         ptr        <= '0;
         pending    <= 1'b0;
         msg_buf    <= '0;
         an         <= AN_OFF;
         seg        <= SEG_OFF;
         frame_done <= 1'b0;
      end else if (msg_load) begin
         // Load wins over everything; a coincident advance is dropped
         state      <= ST_BLANK;
         digit      <= 2'd0;
         cnt        <= '0;
         ptr        <= '0;
         pending    <= 1'b0;
         msg_buf    <= msg_data;
         an         <= AN_OFF;
         seg        <= SEG_OFF;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         pending    <= pending | advance;
         unique case (state)
            ST_BLANK: begin
               if (cnt == CNT_BLANK_LAST) begin
                  state <= ST_DRIVE;
                  cnt   <= '0;
                  an    <= ~(4'b1000 >> digit);
                  seg   <= seg_dec;
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            ST_DRIVE: begin
               if (cnt == CNT_DRIVE_LAST) begin
                  state <= ST_BLANK;
                  cnt   <= '0;
                  digit <= digit + 2'd1;
                  an    <= AN_OFF;
                  seg   <= SEG_OFF;
                  if (digit == 2'd3) begin
                     frame_done <= 1'b1;
                     if (pending) begin
                        ptr <= ptr_next;
                     end
                     // An advance in the boundary cycle belongs to the next frame
                     pending <= advance;
                  end
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            default: state <= ST_BLANK;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench: the driver pushes the expected {an,seg,frame_done} for
// each edge, a negedge monitor pops and compares.
module tb_seg_scan_controller;

   localparam int DEAD    = 2;
   localparam int DIV_MAX = 3;
   localparam int MSG_LEN = 8;
   localparam int SLOT    = DEAD + DIV_MAX + 1;
   localparam int FRAME   = 4 * SLOT;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 msg_load = 1'b0;
   logic [4*MSG_LEN-1:0] msg_data = '0;
   logic                 advance = 1'b0;
   logic [3:0]           an;
   logic [6:0]           seg;
   logic                 frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   logic [11:0] exp_q[$];

   // Reference model state
   int         k;
   int         ptr_m;
   int         pend_m;
   logic [3:0] msg_m [MSG_LEN];
   logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   seg_scan_controller #(
      .DIV_W   (16),
      .DIV_MAX (DIV_MAX),
      .DEAD    (DEAD),
      .MSG_LEN (MSG_LEN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .msg_load   (msg_load),
      .msg_data   (msg_data),
      .advance    (advance),
      .an         (an),
      .seg        (seg),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got an=%b seg=%b fd=%b, expected an=%b seg=%b fd=%b",
                  name, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
      end
   endtask

   function automatic logic [11:0] model_out();
      int         slot;
      int         dg;
      logic [3:0] a;
      logic [6:0] s;
      logic       fd;
      slot = k % FRAME;
      dg   = slot / SLOT;
      fd   = (k > 0) && (slot == 0);
      a    = 4'b1111;
      s    = 7'b1111111;
      if ((slot % SLOT) >= DEAD) begin
         a[3-dg] = 1'b0;
         s       = dec[msg_m[(ptr_m + dg) % MSG_LEN]];
      end
      return {a, s, fd};
   endfunction

   task automatic model_clear();
      k      = 0;
      ptr_m  = 0;
      pend_m = 0;
      for (int j = 0; j < MSG_LEN; j++) msg_m[j] = 4'h0;
   endtask

   // One clock: apply inputs, predict the post-edge outputs, wait past the edge
   task automatic step(input logic ld, input logic [4*MSG_LEN-1:0] d, input logic adv);
      msg_load = ld;
      msg_data = d;
      advance  = adv;
      if (ld) begin
         for (int j = 0; j < MSG_LEN; j++) msg_m[j] = d[4*j +: 4];
         k      = 0;
         ptr_m  = 0;
         pend_m = 0;
      end else begin
         k++;
         if (k % FRAME == 0) begin
            ptr_m  = (ptr_m + pend_m) % MSG_LEN;
            pend_m = int'(adv);
         end else if (adv) begin
            pend_m = 1;
         end
      end
      exp_q.push_back(model_out());
      @(negedge clk);
      #1;
      msg_load = 1'b0;
      advance  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
   endtask

   task automatic align_frame();
      while (k % FRAME != 0) step(1'b0, '0, 1'b0);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         check("scan", {an, seg, frame_done}, exp_q.pop_front());
      end
   end

   initial begin
      model_clear();
      #2 reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("reset_state", {an, seg, frame_done}, {4'b1111, 7'b1111111, 1'b0});
      reset = 1'b1;

      // Power-up scan of an all-zero buffer, through the first frame boundary
      idle(30);

      // Load and watch two frames
      step(1'b1, 32'h7654_3210, 1'b0);
      idle(50);

      // Three advances within one frame collapse to one scroll
      align_frame();
      for (int i = 0; i < FRAME; i++) step(1'b0, '0, (i == 3) || (i == 9) || (i == 17));
      idle(2 * FRAME);

      // One advance per frame across the wrap point
      align_frame();
      for (int f = 0; f < 8; f++) begin
         int pos;
         pos = $urandom_range(0, FRAME - 2);
         for (int i = 0; i < FRAME; i++) step(1'b0, '0, i == pos);
      end
      idle(FRAME + 4);

      // Load in DRIVE(digit 2), cnt 1, with advance pending and coincident
      step(1'b0, '0, 1'b1);
      while (k % FRAME != 2 * SLOT + DEAD + 1) step(1'b0, '0, 1'b0);
      step(1'b1, 32'hFEDC_BA98, 1'b1);
      idle(2 * FRAME);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic ld;
         ld = ($urandom_range(0, 79) == 0);
         step(ld, $urandom, $urandom_range(0, 11) == 0);
      end

      // Asynchronous reset in the middle of a DRIVE phase
      while ((k % SLOT) < DEAD || (k % SLOT) == SLOT - 1) step(1'b0, '0, 1'b0);
      reset = 1'b0;
      #1;
      check("async_reset", {an, seg, frame_done}, {4'b1111, 7'b1111111, 1'b0});
      @(negedge clk);
      #1;
      reset = 1'b1;
      model_clear();
      idle(FRAME + 6);

      // Drain
      for (int i = 0; i < 4; i++) begin
         if (exp_q.size() > 0) @(negedge clk);
      end
      #1;
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d queued, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
